// File: rtl/psum_requantizer_pkg.sv
// Shared types and rounding/saturation helpers for the psum requantizer.
// Helpers work on a fixed 64-bit datapath so any parameter set up to 64 bits fits.
package psum_requantizer_pkg;

  localparam int FN_W = 64;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  typedef struct packed {
    logic            sat;
    logic [FN_W-1:0] val;
  } clamp_t;

  function automatic logic signed [FN_W-1:0] round_shift(
    input logic signed [FN_W-1:0] a,
    input int unsigned            sh
  );
    logic signed [FN_W-1:0] bias;
    bias = '0;
    if (sh != 0) bias[sh-1] = 1'b1;
    return (a + bias) >>> sh;
  endfunction

  function automatic clamp_t sat_clamp(
    input logic signed [FN_W-1:0] r,
    input int unsigned            ow
  );
    logic signed [FN_W-1:0] hi;
    logic signed [FN_W-1:0] lo;
    clamp_t                 c;
    hi    = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo    = -hi - 64'sd1;
    c.sat = (r > hi) || (r < lo);
    if (r > hi)      c.val = hi;
    else if (r < lo) c.val = lo;
    else             c.val = r;
    return c;
  endfunction

endpackage

// File: rtl/psum_requantizer_requantizer.sv
// Combinational round-half-up arithmetic shift followed by saturation
// of the completed accumulator down to the output width.
module requantizer
  import psum_requantizer_pkg::*;
#(
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 16,
  parameter int SH_WIDTH  = 6
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic        [SH_WIDTH-1:0]  sh,
  output logic signed [OUT_WIDTH-1:0] res,
  output logic                        sat
);

  logic signed [FN_W-1:0] wide;
  logic signed [FN_W-1:0] rnd;
  clamp_t                 c;
  logic                   unused_hi;

  always_comb begin
    wide = FN_W'(acc);
    rnd  = round_shift(wide, 32'(sh));
    c    = sat_clamp(rnd, OUT_WIDTH);
    res  = c.val[OUT_WIDTH-1:0];
    sat  = c.sat;
  end

  assign unused_hi = ^c.val[FN_W-1:OUT_WIDTH];

  if (ACC_WIDTH > FN_W) begin : g_acc_chk
    $error("ACC_WIDTH exceeds rounding datapath");
  end
  if ((2 ** SH_WIDTH) > FN_W) begin : g_sh_chk
    $error("SH_WIDTH too wide for rounding datapath");
  end
  if (OUT_WIDTH >= ACC_WIDTH) begin : g_out_chk
    $error("OUT_WIDTH must be narrower than ACC_WIDTH");
  end

endmodule

// File: rtl/psum_requantizer.sv
// Accumulates a group of MAC partial sums, requantizes the total and
// presents it on a registered valid/ready output.
module psum_requantizer
  import psum_requantizer_pkg::*;
#(
  parameter int IN_WIDTH  = 38,
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 16,
  parameter int MAX_ACC   = 64,
  parameter int CNT_WIDTH = $clog2(MAX_ACC + 1),
  parameter int SH_WIDTH  = 6
) (
  input  logic                        clk,
  input  logic                        rst_in,
  input  logic                        in_valid,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        in_ready,
  input  logic        [CNT_WIDTH-1:0] acc_len,
  input  logic        [SH_WIDTH-1:0]  shift,
  input  logic                        abort_in,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_sat,
  input  logic                        out_ready,
  output logic                        busy
);

  state_t                      state, state_n;
  logic signed [ACC_WIDTH-1:0] acc, acc_n;
  logic signed [ACC_WIDTH-1:0] in_ext, sum;
  logic        [CNT_WIDTH-1:0] cnt, cnt_n;
  logic        [CNT_WIDTH-1:0] len, len_n, len_eff;
  logic        [SH_WIDTH-1:0]  sh, sh_n;
  logic                        beat;
  logic                        done;
  logic signed [ACC_WIDTH-1:0] done_acc;
  logic        [SH_WIDTH-1:0]  done_sh;
  logic signed [OUT_WIDTH-1:0] q_data;
  logic                        q_sat;

  // in_ready depends combinationally on out_ready so a drain frees a slot
  assign in_ready = !abort_in && (!out_valid || out_ready);
  assign beat     = in_valid && in_ready;
  assign busy     = (state == ACCUM);
  assign in_ext   = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
  assign sum      = acc + in_ext;
  assign len_eff  = (acc_len == '0) ? CNT_WIDTH'(1) : acc_len;

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    cnt_n    = cnt;
    len_n    = len;
    sh_n     = sh;
    done     = 1'b0;
    done_acc = sum;
    done_sh  = sh;
    unique case (state)
      IDLE: begin
        if (beat) begin
          len_n    = len_eff;
          sh_n     = shift;
          acc_n    = in_ext;
          done_acc = in_ext;
          done_sh  = shift;
          if (len_eff == CNT_WIDTH'(1)) begin
            done  = 1'b1;
            cnt_n = '0;
          end else begin
            cnt_n   = CNT_WIDTH'(1);
            state_n = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (abort_in) begin
          acc_n   = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (beat) begin
          acc_n = sum;
          cnt_n = cnt + CNT_WIDTH'(1);
          if (cnt == len - CNT_WIDTH'(1)) begin
            done    = 1'b1;
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  requantizer #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SH_WIDTH  (SH_WIDTH)
  ) u_rq (
    .acc (done_acc),
    .sh  (done_sh),
    .res (q_data),
    .sat (q_sat)
  );

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      len       <= '0;
      sh        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      len   <= len_n;
      sh    <= sh_n;
      // a fresh result takes priority over a drain in the same cycle
      if (done) begin
        out_valid <= 1'b1;
        out_data  <= q_data;
        out_sat   <= q_sat;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  a_len_legal : assert property (
    @(posedge clk) disable iff (rst_in)
    (beat && state == IDLE) |-> (acc_len <= CNT_WIDTH'(MAX_ACC))
  ) else $error("acc_len above MAX_ACC");

  if (ACC_WIDTH < IN_WIDTH + $clog2(MAX_ACC)) begin : g_acc_chk
    $error("ACC_WIDTH too narrow for MAX_ACC sums");
  end

endmodule

// File: tb/tb_psum_requantizer.sv
// Directed bench for psum_requantizer with a result scoreboard.
module tb_psum_requantizer;

  localparam int IW = 38;
  localparam int OW = 16;
  localparam int CW = 7;
  localparam int SW = 6;

  logic                 clk = 1'b0;
  logic                 rst_in;
  logic                 in_valid;
  logic signed [IW-1:0] in_data;
  logic                 in_ready;
  logic        [CW-1:0] acc_len;
  logic        [SW-1:0] shift;
  logic                 abort_in;
  logic                 out_valid;
  logic signed [OW-1:0] out_data;
  logic                 out_sat;
  logic                 out_ready;
  logic                 busy;

  typedef struct {
    int data;
    bit sat;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  psum_requantizer dut (
    .clk       (clk),
    .rst_in    (rst_in),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .acc_len   (acc_len),
    .shift     (shift),
    .abort_in  (abort_in),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input bit s);
    exp_t e;
    e.data = d;
    e.sat  = s;
    sb.push_back(e);
  endtask

  task automatic send(input longint d, input int len, input int sh);
    int w;
    w        = 0;
    in_valid = 1'b1;
    in_data  = d[IW-1:0];
    acc_len  = len[CW-1:0];
    shift    = sh[SW-1:0];
    #0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    if (w == 50) chk("send_timeout", in_ready, 1);
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  always @(negedge clk) begin
    if (!rst_in && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", out_valid, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_data", out_data, e.data);
        chk("sb_sat", out_sat, e.sat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in    = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    acc_len   = '0;
    shift     = '0;
    abort_in  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst_in = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 1);

    // group of four, no shift
    send(10, 4, 0);
    chk("t1_busy", busy, 1);
    send(20, 4, 0);
    send(-5, 4, 0);
    chk("t1_pre", out_valid, 0);
    push(32, 0);
    send(7, 4, 0);
    chk("t1_lat", out_valid, 1);
    chk("t1_idle", busy, 0);
    idle();

    // single-beat groups with rounding
    push(2, 0);
    send(6, 1, 2);
    chk("t2_v0", out_valid, 1);
    push(-1, 0);
    send(-6, 1, 2);
    chk("t2_v1", out_valid, 1);
    push(1, 0);
    send(5, 1, 2);
    chk("t2_v2", out_valid, 1);
    idle();

    // saturation both ways
    push(32767, 1);
    send(40000, 2, 0);
    send(1, 2, 0);
    push(-32768, 1);
    send(-40000, 2, 0);
    send(-1, 2, 0);
    idle();

    // backpressure holds the result
    out_ready = 1'b0;
    push(7, 0);
    send(7, 1, 0);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_rdy", in_ready, 0);
      chk("t4_valid", out_valid, 1);
      chk("t4_data", out_data, 7);
    end
    out_ready = 1'b1;
    tick();
    chk("t4_drained", out_valid, 0);
    send(1, 4, 0);
    send(2, 4, 0);
    send(3, 4, 0);
    push(10, 0);
    send(4, 4, 0);
    idle();

    // abort mid-group
    send(100, 4, 0);
    send(100, 4, 0);
    chk("t5_busy", busy, 1);
    in_valid = 1'b1;
    in_data  = 100;
    abort_in = 1'b1;
    #1;
    chk("t5_abort_rdy", in_ready, 0);
    tick();
    abort_in = 1'b0;
    in_valid = 1'b0;
    chk("t5_busy0", busy, 0);
    chk("t5_noout", out_valid, 0);
    tick();
    chk("t5_noout2", out_valid, 0);
    send(1, 4, 0);
    send(1, 4, 0);
    send(1, 4, 0);
    push(4, 0);
    send(1, 4, 0);
    idle();
    tick();

    // reset mid-group
    send(5, 4, 0);
    send(5, 4, 0);
    send(5, 4, 0);
    in_valid = 1'b0;
    rst_in   = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("t6_valid", out_valid, 0);
    chk("t6_data", out_data, 0);
    chk("t6_sat", out_sat, 0);
    chk("t6_busy", busy, 0);
    push(9, 0);
    send(9, 0, 0);
    chk("t6_len0", out_valid, 1);
    idle();
    for (int i = 0; i < 63; i++) begin
      send((64'sd1 <<< 37) - 1, 64, 29);
      chk("t6_busy_max", busy, 1);
    end
    push(16384, 0);
    send((64'sd1 <<< 37) - 1, 64, 29);
    idle();
    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
